// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // Size lives in funct3[1:0]; unsigned variants share the byte-enable pattern.
  function automatic logic [3:0] gen_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   gen_be = 4'b0001 << a;
      2'b01:   gen_be = 4'b0011 << {a[1], 1'b0};
      default: gen_be = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      MEM_H, MEM_HU: is_misaligned = a[0];
      MEM_W:         is_misaligned = (a != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side, data-memory and writeback signals of mem_stage.
// MEM_MISALIGN_CHECK_EN adds the mem_misaligned_out flag.
interface mem_stage_if #(parameter int XLEN = 32);
  logic            ex_mem_valid_inst;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_regb;
  logic            ex_mem_rd_mem;
  logic            ex_mem_wr_mem;
  logic [2:0]      ex_mem_funct3;
  logic [4:0]      ex_mem_dest_reg;
  logic            mem_stall_out;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_wb_valid;
  logic [XLEN-1:0] mem_wb_result;
  logic [4:0]      mem_wb_dest_reg;
`ifdef MEM_MISALIGN_CHECK_EN
  logic            mem_misaligned_out;
`endif

  modport master (
    input  ex_mem_valid_inst, ex_mem_alu_result, ex_mem_regb, ex_mem_rd_mem,
           ex_mem_wr_mem, ex_mem_funct3, ex_mem_dest_reg,
           mem_gnt, mem_rvalid, mem_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
    output mem_misaligned_out,
`endif
    output mem_stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           mem_wb_valid, mem_wb_result, mem_wb_dest_reg
  );

  modport slave (
    output ex_mem_valid_inst, ex_mem_alu_result, ex_mem_regb, ex_mem_rd_mem,
           ex_mem_wr_mem, ex_mem_funct3, ex_mem_dest_reg,
           mem_gnt, mem_rvalid, mem_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
    input  mem_misaligned_out,
`endif
    input  mem_stall_out, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           mem_wb_valid, mem_wb_result, mem_wb_dest_reg
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load data formatter: picks the byte/half lane and sign- or zero-extends.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      MEM_B:   data_o = {{(XLEN-8){b[7]}}, b};
      MEM_BU:  data_o = {{(XLEN-8){1'b0}}, b};
      MEM_H:   data_o = {{(XLEN-16){h[15]}}, h};
      MEM_HU:  data_o = {{(XLEN-16){1'b0}}, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: IDLE/REQ/WAIT transaction FSM, store lane
// formatting, load alignment, registered writeback. Option: MEM_MISALIGN_CHECK_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.master bus
);

  state_e          state_q;
  logic            is_load_q;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;
  logic [4:0]      dest_q;
  logic            req_q, we_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      be_q;
  logic            wb_valid_q;
  logic [XLEN-1:0] wb_result_q;
  logic [4:0]      wb_dest_q;

  logic            mem_op, misal, timeout, done;
  logic [XLEN-1:0] rdata_eff, load_data, wdata_fmt;

  assign mem_op = bus.ex_mem_valid_inst & (bus.ex_mem_rd_mem | bus.ex_mem_wr_mem);

`ifdef MEM_MISALIGN_CHECK_EN
  logic misal_q;
  assign misal = is_misaligned(bus.ex_mem_funct3, bus.ex_mem_alu_result[1:0]);
  assign bus.mem_misaligned_out = misal_q;
`else
  assign misal = 1'b0;
`endif

  generate
    if (MEM_TIMEOUT > 0) begin : g_tmo
      logic [31:0] cnt_q;
      always_ff @(posedge clk) begin
        if (!rst || state_q != WAIT) cnt_q <= '0;
        else                         cnt_q <= cnt_q + 32'd1;
      end
      assign timeout = (cnt_q == 32'(MEM_TIMEOUT - 1));
    end else begin : g_no_tmo
      assign timeout = 1'b0;
    end
  endgenerate

  // A forced completion formats an all-zero word.
  assign done      = (state_q == WAIT) & (bus.mem_rvalid | timeout);
  assign rdata_eff = bus.mem_rvalid ? bus.mem_rdata : '0;

  load_align #(.XLEN(XLEN)) u_align (
    .rdata_i  (rdata_eff),
    .addr_i   (lane_q),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    case (bus.ex_mem_funct3[1:0])
      2'b00:   wdata_fmt = {(XLEN/8){bus.ex_mem_regb[7:0]}};
      2'b01:   wdata_fmt = {(XLEN/16){bus.ex_mem_regb[15:0]}};
      default: wdata_fmt = bus.ex_mem_regb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      f3_q        <= '0;
      lane_q      <= '0;
      dest_q      <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_dest_q   <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misal_q     <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misal_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (mem_op && misal) begin
            wb_valid_q  <= 1'b1;
            wb_result_q <= '0;
            wb_dest_q   <= bus.ex_mem_dest_reg;
`ifdef MEM_MISALIGN_CHECK_EN
            misal_q     <= 1'b1;
`endif
          end else if (mem_op) begin
            // Load wins when both rd_mem and wr_mem are set.
            is_load_q <= bus.ex_mem_rd_mem;
            we_q      <= ~bus.ex_mem_rd_mem;
            f3_q      <= bus.ex_mem_funct3;
            lane_q    <= bus.ex_mem_alu_result[1:0];
            dest_q    <= bus.ex_mem_dest_reg;
            addr_q    <= {bus.ex_mem_alu_result[XLEN-1:2], 2'b00};
            be_q      <= gen_be(bus.ex_mem_funct3, bus.ex_mem_alu_result[1:0]);
            wdata_q   <= wdata_fmt;
            req_q     <= 1'b1;
            state_q   <= REQ;
          end else if (bus.ex_mem_valid_inst) begin
            wb_valid_q  <= 1'b1;
            wb_result_q <= bus.ex_mem_alu_result;
            wb_dest_q   <= bus.ex_mem_dest_reg;
          end
        end
        REQ: begin
          if (bus.mem_gnt) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            wb_valid_q  <= 1'b1;
            wb_result_q <= is_load_q ? load_data : '0;
            wb_dest_q   <= is_load_q ? dest_q : 5'd0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_stall_out = rst & (((state_q == IDLE) & mem_op) |
                                    (state_q == REQ) |
                                    ((state_q == WAIT) & ~done));
  assign bus.mem_req         = req_q;
  assign bus.mem_we          = we_q;
  assign bus.mem_addr        = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_be          = be_q;
  assign bus.mem_wb_valid    = wb_valid_q;
  assign bus.mem_wb_result   = wb_result_q;
  assign bus.mem_wb_dest_reg = wb_dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: default DUT plus a MEM_TIMEOUT=3 instance.
module tb_mem_stage;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(32)) bus ();
  mem_stage_if #(.XLEN(32)) bus2 ();

  mem_stage #(.XLEN(32), .MEM_TIMEOUT(0)) dut     (.clk(clk), .rst(rst), .bus(bus));
  mem_stage #(.XLEN(32), .MEM_TIMEOUT(3)) dut_tmo (.clk(clk), .rst(rst), .bus(bus2));

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_mem_valid_inst = 0; bus.ex_mem_alu_result = '0; bus.ex_mem_regb = '0;
    bus.ex_mem_rd_mem = 0; bus.ex_mem_wr_mem = 0; bus.ex_mem_funct3 = '0;
    bus.ex_mem_dest_reg = '0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    bus2.ex_mem_valid_inst = 0; bus2.ex_mem_alu_result = '0; bus2.ex_mem_regb = '0;
    bus2.ex_mem_rd_mem = 0; bus2.ex_mem_wr_mem = 0; bus2.ex_mem_funct3 = '0;
    bus2.ex_mem_dest_reg = '0; bus2.mem_gnt = 0; bus2.mem_rvalid = 0; bus2.mem_rdata = '0;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] regb,
                       input logic rd, input logic wr, input logic [2:0] f3, input logic [4:0] d);
    bus.ex_mem_valid_inst = v; bus.ex_mem_alu_result = alu; bus.ex_mem_regb = regb;
    bus.ex_mem_rd_mem = rd; bus.ex_mem_wr_mem = wr; bus.ex_mem_funct3 = f3;
    bus.ex_mem_dest_reg = d;
  endtask

  // Full load with gnt in the first REQ cycle and rvalid in the first WAIT cycle.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input logic [4:0] d);
    drive(1, addr, 32'h0, 1, 0, f3, d);
    tick();
    bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = rdata;
    tick();
    bus.mem_rvalid = 0;
    drive(0, 32'h0, 32'h0, 0, 0, 3'b000, 5'd0);
  endtask

  task automatic test_reset();
    rst = 0;
    drive(1, 32'h104, 32'h0, 1, 0, MEM_W, 5'd1);
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    tests++;
    if (bus.mem_stall_out !== 1'b0) begin
      fails++; $display("FAIL reset_stall: got %b want 0", bus.mem_stall_out);
    end
    tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
         bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%b wbv=%b res=%h dst=%0d want all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
               bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg);
    end
    // Stray gnt/rvalid in IDLE with no instruction must be ignored.
    drive(0, 32'h0, 32'h0, 0, 0, 3'b000, 5'd0);
    rst = 1;
    tick();
    tests++;
    if ({bus.mem_req, bus.mem_wb_valid} !== 2'b00) begin
      fails++; $display("FAIL stray_handshake: req/wbv got %b want 00", {bus.mem_req, bus.mem_wb_valid});
    end
    idle_inputs();
  endtask

  task automatic test_non_mem();
    drive(1, 32'h0000_1234, 32'h0, 0, 0, 3'b000, 5'd5);
    #1;
    tests++;
    if (bus.mem_stall_out !== 1'b0) begin
      fails++; $display("FAIL nonmem_stall: got %b want 0", bus.mem_stall_out);
    end
    tick();
    tests++;
    if ({bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg, bus.mem_req} !== {1'b1, 32'h1234, 5'd5, 1'b0}) begin
      fails++; $display("FAIL nonmem_wb: wbv=%b res=%h dst=%0d req=%b want 1 00001234 5 0",
                        bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg, bus.mem_req);
    end
    // Not valid but flagged as load: no access, no writeback, no stall.
    drive(0, 32'h100, 32'h0, 1, 1, MEM_W, 5'd6);
    #1;
    tests++;
    if (bus.mem_stall_out !== 1'b0) begin
      fails++; $display("FAIL invalid_stall: got %b want 0", bus.mem_stall_out);
    end
    tick();
    tests++;
    if ({bus.mem_wb_valid, bus.mem_req} !== 2'b00) begin
      fails++; $display("FAIL invalid_noop: wbv/req got %b want 00", {bus.mem_wb_valid, bus.mem_req});
    end
    idle_inputs();
  endtask

  task automatic test_lb();
    drive(1, 32'h103, 32'h0, 1, 0, MEM_B, 5'd7);
    #1;
    tests++;
    if (bus.mem_stall_out !== 1'b1) begin
      fails++; $display("FAIL lb_accept_stall: got %b want 1", bus.mem_stall_out);
    end
    tick();
    tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wb_valid} !== {1'b1, 1'b0, 32'h100, 4'b1000, 1'b0}) begin
      fails++; $display("FAIL lb_req: req=%b we=%b addr=%h be=%b wbv=%b want 1 0 00000100 1000 0",
                        bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wb_valid);
    end
    bus.mem_gnt = 1;
    tick();
    tests++;
    if ({bus.mem_req, bus.mem_wb_valid} !== 2'b00) begin
      fails++; $display("FAIL lb_wait: req/wbv got %b want 00", {bus.mem_req, bus.mem_wb_valid});
    end
    bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h80FF_0000;
    #1;
    tests++;
    if (bus.mem_stall_out !== 1'b0) begin
      fails++; $display("FAIL lb_release_stall: got %b want 0", bus.mem_stall_out);
    end
    tick();
    tests++;
    if ({bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg} !== {1'b1, 32'hFFFF_FF80, 5'd7}) begin
      fails++; $display("FAIL lb_wb: wbv=%b res=%h dst=%0d want 1 ffffff80 7",
                        bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg);
    end
    idle_inputs();
    tick();
    tests++;
    if (bus.mem_wb_valid !== 1'b0) begin
      fails++; $display("FAIL lb_single_pulse: wbv got %b want 0", bus.mem_wb_valid);
    end
  endtask

  task automatic test_stores();
    logic [31:0] ad[3], rb[3], exp_wd[3];
    logic [2:0]  f3[3];
    logic [3:0]  exp_be[3];
    ad = '{32'h202, 32'h101, 32'h204};
    rb = '{32'hDEAD_BEEF, 32'h1234_56A5, 32'hCAFE_F00D};
    f3 = '{MEM_H, MEM_B, MEM_W};
    exp_be = '{4'b1100, 4'b0010, 4'b1111};
    exp_wd = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      drive(1, ad[i], rb[i], 0, 1, f3[i], 5'd9);
      tick();
      tests++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !==
          {1'b1, 1'b1, {ad[i][31:2], 2'b00}, exp_be[i], exp_wd[i]}) begin
        fails++; $display("FAIL store_req[%0d]: req=%b we=%b addr=%h be=%b wdata=%h want be=%b wdata=%h",
                          i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, exp_be[i], exp_wd[i]);
      end
      bus.mem_gnt = 1;
      tick();
      bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h5555_5555;
      tick();
      tests++;
      if ({bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg} !== {1'b1, 32'h0, 5'd0}) begin
        fails++; $display("FAIL store_wb[%0d]: wbv=%b res=%h dst=%0d want 1 00000000 0",
                          i, bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg);
      end
      idle_inputs();
    end
  endtask

  task automatic test_loads();
    logic [31:0] ad[7], rd[7], exp[7];
    logic [2:0]  f3[7];
    ad  = '{32'h102, 32'h102, 32'h100, 32'h101, 32'h101, 32'h104, 32'h10C};
    f3  = '{MEM_HU, MEM_H, MEM_H, MEM_BU, MEM_B, MEM_W, 3'b011};
    rd  = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF, 32'h0000_9A00, 32'h0000_9A00,
            32'hA5A5_5A5A, 32'h0102_0304};
    exp = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_7FFF, 32'h0000_009A, 32'hFFFF_FF9A,
            32'hA5A5_5A5A, 32'h0102_0304};
    for (int i = 0; i < 7; i++) begin
      run_load(ad[i], f3[i], rd[i], 5'd10);
      tests++;
      if ({bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg} !== {1'b1, exp[i], 5'd10}) begin
        fails++; $display("FAIL load_fmt[%0d]: wbv=%b res=%h dst=%0d want 1 %h 10",
                          i, bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg, exp[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_gnt_delay();
    int pulses = 0;
    int bad = 0;
    drive(1, 32'h400, 32'h0, 1, 0, MEM_W, 5'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.mem_gnt = 1;
      #1;
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === 32'h400 && bus.mem_be === 4'b1111 &&
            bus.mem_we === 1'b0 && bus.mem_stall_out === 1'b1)) bad++;
      if (bus.mem_wb_valid === 1'b1) pulses++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL gnt_delay_hold: %0d unstable REQ cycles, want 0", bad);
    end
    bus.mem_gnt = 0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678; end
      #1;
      if (bus.mem_stall_out !== (i == 0)) bad++;
      if (bus.mem_req !== 1'b0) bad++;
      if (bus.mem_wb_valid === 1'b1) pulses++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL gnt_delay_wait: %0d bad WAIT cycles, want 0", bad);
    end
    tests++;
    if ({bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg} !== {1'b1, 32'h1234_5678, 5'd3}) begin
      fails++; $display("FAIL gnt_delay_wb: wbv=%b res=%h dst=%0d want 1 12345678 3",
                        bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_wb_valid === 1'b1) pulses++;
      tick();
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL gnt_delay_pulses: got %0d wb pulses want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h800, 32'h0, 1, 0, MEM_W, 5'd6);
    tick();
    bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111_2222;
    tick();
    bus.mem_rvalid = 0;
    drive(1, 32'h55, 32'h0, 0, 0, 3'b000, 5'd4);
    tests++;
    if ({bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg} !== {1'b1, 32'h1111_2222, 5'd6}) begin
      fails++; $display("FAIL b2b_load: wbv=%b res=%h dst=%0d want 1 11112222 6",
                        bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg);
    end
    tick();
    tests++;
    if ({bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg, bus.mem_req} !== {1'b1, 32'h55, 5'd4, 1'b0}) begin
      fails++; $display("FAIL b2b_alu: wbv=%b res=%h dst=%0d req=%b want 1 00000055 4 0",
                        bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg, bus.mem_req);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h500, 32'h0, 1, 0, MEM_W, 5'd8);
    tick();
    bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0;
    rst = 0;
    tick();
    tests++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wb_valid, bus.mem_stall_out} !== '0) begin
      fails++; $display("FAIL rst_mid_clear: req=%b addr=%h be=%b wbv=%b stall=%b want all 0",
                        bus.mem_req, bus.mem_addr, bus.mem_be, bus.mem_wb_valid, bus.mem_stall_out);
    end
    rst = 1;
    drive(0, 32'h0, 32'h0, 0, 0, 3'b000, 5'd0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'hABCD_0123;
    tick();
    tests++;
    if ({bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg, bus.mem_req} !== '0) begin
      fails++; $display("FAIL rst_mid_late_rvalid: wbv=%b res=%h dst=%0d req=%b want all 0",
                        bus.mem_wb_valid, bus.mem_wb_result, bus.mem_wb_dest_reg, bus.mem_req);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    bus2.ex_mem_valid_inst = 1; bus2.ex_mem_alu_result = 32'h602; bus2.ex_mem_rd_mem = 1;
    bus2.ex_mem_funct3 = MEM_H; bus2.ex_mem_dest_reg = 5'd11;
    tick();
    bus2.mem_gnt = 1;
    tick();
    bus2.mem_gnt = 0;
    #1;
    tests++;
    if ({bus2.mem_stall_out, bus2.mem_wb_valid} !== 2'b10) begin
      fails++; $display("FAIL tmo_wait1: stall/wbv got %b want 10", {bus2.mem_stall_out, bus2.mem_wb_valid});
    end
    tick();
    tests++;
    if ({bus2.mem_stall_out, bus2.mem_wb_valid} !== 2'b10) begin
      fails++; $display("FAIL tmo_wait2: stall/wbv got %b want 10", {bus2.mem_stall_out, bus2.mem_wb_valid});
    end
    tick();
    tests++;
    if ({bus2.mem_stall_out, bus2.mem_wb_valid} !== 2'b00) begin
      fails++; $display("FAIL tmo_wait3: stall/wbv got %b want 00", {bus2.mem_stall_out, bus2.mem_wb_valid});
    end
    tick();
    tests++;
    if ({bus2.mem_wb_valid, bus2.mem_wb_result, bus2.mem_wb_dest_reg} !== {1'b1, 32'h0, 5'd11}) begin
      fails++; $display("FAIL tmo_wb: wbv=%b res=%h dst=%0d want 1 00000000 11",
                        bus2.mem_wb_valid, bus2.mem_wb_result, bus2.mem_wb_dest_reg);
    end
    idle_inputs();
    tick();
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misaligned();
    drive(1, 32'h301, 32'h0, 1, 0, MEM_W, 5'd12);
    tick();
    tests++;
    if ({bus.mem_req, bus.mem_wb_valid, bus.mem_misaligned_out, bus.mem_wb_result} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      fails++; $display("FAIL misal_lw: req=%b wbv=%b mis=%b res=%h want 0 1 1 00000000",
                        bus.mem_req, bus.mem_wb_valid, bus.mem_misaligned_out, bus.mem_wb_result);
    end
    idle_inputs();
    tick();
    tests++;
    if ({bus.mem_misaligned_out, bus.mem_wb_valid, bus.mem_req} !== 3'b000) begin
      fails++; $display("FAIL misal_clear: mis/wbv/req got %b want 000",
                        {bus.mem_misaligned_out, bus.mem_wb_valid, bus.mem_req});
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_non_mem();
    test_lb();
    test_stores();
    test_loads();
    test_gnt_delay();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
`ifdef MEM_MISALIGN_CHECK_EN
    test_misaligned();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
